simm_responder: RTL
===================

# simm_responder

Synthesizable responder for the SIMM DRAM port: it sits on the far side of `simm_controller` and behaves as two banks of 32-bit FPM DRAM driven by active-high RAS/CAS lines and a muxed 12-bit address. It handles row opens, CAS-qualified byte-lane reads and writes, and CAS-before-RAS refresh. It also monitors refresh interval and signalling legality. It is used in simulation benches and FPGA self-test builds in place of physical SIMMs.

## Interface
- `ROW_BITS`, 4: modelled row address bits, taken from `addr[ROW_BITS-1:0]`; higher bits are ignored (aliased).
- `COL_BITS`, 4: modelled column address bits, taken from `addr[COL_BITS-1:0]`.
- `REFRESH_LIMIT`, 512: maximum number of clocks allowed between CBR refreshes.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `ras` in 4: active-high RAS lines. 4'b1010 opens bank 0, 4'b0101 opens bank 1, 4'b1111 is refresh.
- `cas` in 4: active-high CAS lines; bit i is byte lane i (`data[8i+7:8i]`).
- `addr` in 12: muxed address, carrying the row while RAS is rising and the column while CAS is rising.
- `we` in 1: write strobe, sampled on the CAS edge.
- `data_in` in 32: write data.
- `data_out` out 32: read data.
- `data_oe` out 1: high while `data_out` is valid.
- `refresh_error` out 1: sticky; refresh interval exceeded.
- `protocol_error` out 1: sticky; illegal RAS/CAS sequence.
- `refresh_count` out 16: number of completed CBR refreshes, wrapping.

## Operation
- Signal sampling:
  - `ras`, `cas`, `addr`, `we` and `data_in` are sampled on every rising `clock`.
  - A registered `cas_prev` marks the CAS edge, defined as `cas_prev==0 && cas!=0`.
- IDLE:
  - `ras==0`, `cas==0`: stay in IDLE.
  - `ras` = bank pattern, `cas==0`: latch row and bank (bank = `ras[0]`), go to ROW_OPEN.
  - `ras==0`, `cas==4'b1111`: go to CBR_PEND.
  - Any other `ras`/`cas` combination: set `protocol_error`, stay in IDLE.
- ROW_OPEN:
  - CAS edge: latch column and go to ACCESS.
    - With `we`: write the lanes whose `cas` bit is set, once, at this edge.
    - Without `we`: read the full word.
  - `ras==0`: go to IDLE.
  - `ras` changes to any other nonzero value: set `protocol_error`, go to IDLE.
- ACCESS:
  - `cas` held: hold the current state and the read data.
  - `cas==0` with RAS held: go to ROW_OPEN (page mode).
  - `ras==0`: go to IDLE.
- CBR_PEND:
  - `ras==4'b1111`: go to REFRESH, increment `refresh_count`, clear the interval counter.
  - `cas` drops before RAS asserts: set `protocol_error`, go to IDLE.
- REFRESH:
  - Stay in REFRESH until `ras==0`, then go to IDLE.
  - CAS may drop first.
- Refresh monitoring:
  - The interval counter increments every clock and saturates.
  - When it reaches `REFRESH_LIMIT`, set `refresh_error`.
  - A refresh that completes in the same cycle as the limit is reached clears the counter and does not set the error.
- Storage:
  - 2 × 2^(ROW_BITS+COL_BITS) words of 32 bits.
  - Contents are not reset.
  - The full RAS deassert path (`ras==0` from ROW_OPEN, ACCESS or REFRESH) takes priority over CAS in the same cycle.

## Timing
- Reset values: `data_out`=0, `data_oe`=0, `refresh_error`=0, `protocol_error`=0, `refresh_count`=0, interval counter 0, state IDLE.
- Reset in mid-operation aborts the access. A partially seen write is committed only if its CAS edge was sampled before reset.
- Read latency: `data_out` and `data_oe` are valid 1 clock after the CAS edge is sampled. They stay valid while in ACCESS with `we` low. `data_oe` drops in the cycle after `cas` or `ras` deasserts.
- Write: the array is updated at the CAS-edge clock. A read-after-write to the same word in the next access returns the new data.
- Against the controller's sequence (RAS, one cycle, mux to column, one cycle, CAS): a read returns data 3 clocks after RAS asserts.

## Configuration
- `SIMM_RESPONDER_CHECK_EN` defined: the interval counter, `refresh_error` and `protocol_error` logic are compiled in.
- `SIMM_RESPONDER_CHECK_EN` undefined: both error outputs are tied to 0 and the interval counter is removed.
- `refresh_count` and all data behaviour are identical in both builds.

## Structure
- Package `simm_responder_pkg`: state enum (IDLE, ROW_OPEN, ACCESS, CBR_PEND, REFRESH) and constants `RAS_BANK0`=4'b1010, `RAS_BANK1`=4'b0101, `RAS_ALL`=4'b1111, `CAS_ALL`=4'b1111.
- Sub-module `simm_responder_array`: byte-lane-writable storage with a registered read port, indexed by {bank, row, col}.

## Test plan
- Write 0xDEADBEEF to bank 0, row 3, col 5 with cas=1111, then read the same location → `data_out`=0xDEADBEEF, `data_oe` high 1 clock after the CAS edge.
- Write 0x11223344, then write 0xAABBCCDD to the same word with cas=0101, then read → 0x11BB33DD.
- Same row/col in bank 1 with `ras`=0101 after a bank-0 write → bank-0 data is unaffected; the bank-1 value reads back independently.
- CBR refresh (cas=1111, ras=1111, cas=0, ras=0) every 251 clocks for 2000 clocks → `refresh_count` increments per refresh and `refresh_error` stays 0.
- No refresh for 512 clocks → `refresh_error`=1 on the 512th clock and stays set through subsequent refreshes until reset.
- `ras`=4'b0011 from IDLE, or cas dropping in CBR_PEND → `protocol_error`=1. With `SIMM_RESPONDER_CHECK_EN` undefined, `protocol_error` stays 0.

Source files
------------

// File: rtl/simm_responder_pkg.sv
// Shared types and constants for the SIMM DRAM responder: FSM states and
// the RAS/CAS line patterns the controller drives.
package simm_responder_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW_OPEN = 3'd1,
    ACCESS   = 3'd2,
    CBR_PEND = 3'd3,
    REFRESH  = 3'd4
  } state_e;

  localparam logic [3:0] RAS_BANK0 = 4'b1010;
  localparam logic [3:0] RAS_BANK1 = 4'b0101;
  localparam logic [3:0] RAS_ALL   = 4'b1111;
  localparam logic [3:0] CAS_ALL   = 4'b1111;

  function automatic logic [3:0] ras_for_bank(input logic bank);
    return bank ? RAS_BANK1 : RAS_BANK0;
  endfunction

  function automatic logic is_bank_pattern(input logic [3:0] ras);
    return (ras == RAS_BANK0) || (ras == RAS_BANK1);
  endfunction

endpackage

// File: rtl/simm_responder_array.sv
// Word storage for both banks: per-byte-lane write enables and a registered
// read port. Contents are deliberately left unreset; only the read register is.
module simm_responder_array #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 wr_en_i,
  input  logic [3:0]           wr_lanes_i,
  input  logic [31:0]          wr_data_i,
  input  logic                 rd_en_i,
  output logic [31:0]          rd_data_o
);

  logic [31:0] mem_q [2**ADDR_BITS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes_i[i]) mem_q[addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/simm_responder.sv
// Two-bank FPM DRAM responder for the SIMM port (row open, CAS byte-lane access,
// CBR refresh). Define SIMM_RESPONDER_CHECK_EN to build the refresh/protocol monitors.
module simm_responder
  import simm_responder_pkg::*;
#(
  parameter int ROW_BITS      = 4,
  parameter int COL_BITS      = 4,
  parameter int REFRESH_LIMIT = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ras,
  input  logic [3:0]  cas,
  input  logic [11:0] addr,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_oe,
  output logic        refresh_error,
  output logic        protocol_error,
  output logic [15:0] refresh_count
);

  localparam int ADDR_BITS = 1 + ROW_BITS + COL_BITS;
  localparam int ADDR_USED = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;

  state_e              state_q;
  logic [3:0]          cas_prev_q;
  logic                bank_q;
  logic [ROW_BITS-1:0] row_q;
  logic                data_oe_q;
  logic [15:0]         refresh_count_q;

  logic                 cas_edge;
  logic                 ras_held;
  logic                 access_fire;
  logic                 refresh_fire;
  logic                 proto_viol;
  logic [ADDR_BITS-1:0] arr_addr;

  assign cas_edge     = (cas_prev_q == 4'b0000) && (cas != 4'b0000);
  assign ras_held     = (ras == ras_for_bank(bank_q));
  assign access_fire  = (state_q == ROW_OPEN) && ras_held && cas_edge;
  assign refresh_fire = (state_q == CBR_PEND) && (ras == RAS_ALL);
  assign arr_addr     = {bank_q, row_q, addr[COL_BITS-1:0]};

  always_comb begin
    proto_viol = 1'b0;
    case (state_q)
      IDLE: proto_viol = !((ras == 4'b0000) && (cas == 4'b0000)) &&
                         !(is_bank_pattern(ras) && (cas == 4'b0000)) &&
                         !((ras == 4'b0000) && (cas == CAS_ALL));
      ROW_OPEN,
      ACCESS:   proto_viol = (ras != 4'b0000) && !ras_held;
      CBR_PEND: proto_viol = (ras != RAS_ALL) && ((cas != CAS_ALL) || (ras != 4'b0000));
      default:  proto_viol = 1'b0;
    endcase
  end

  // RAS deassert is checked before the CAS edge so it wins in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cas_prev_q      <= 4'b0000;
      bank_q          <= 1'b0;
      row_q           <= '0;
      data_oe_q       <= 1'b0;
      refresh_count_q <= 16'd0;
    end else begin
      cas_prev_q <= cas;
      case (state_q)
        IDLE: begin
          if ((ras == 4'b0000) && (cas == CAS_ALL)) begin
            state_q <= CBR_PEND;
          end else if (is_bank_pattern(ras) && (cas == 4'b0000)) begin
            row_q   <= addr[ROW_BITS-1:0];
            bank_q  <= ras[0];
            state_q <= ROW_OPEN;
          end
        end
        ROW_OPEN: begin
          if ((ras == 4'b0000) || !ras_held) begin
            state_q <= IDLE;
          end else if (cas_edge) begin
            state_q   <= ACCESS;
            data_oe_q <= !we;
          end
        end
        ACCESS: begin
          if ((ras == 4'b0000) || !ras_held) begin
            state_q   <= IDLE;
            data_oe_q <= 1'b0;
          end else if (cas == 4'b0000) begin
            state_q   <= ROW_OPEN;
            data_oe_q <= 1'b0;
          end
        end
        CBR_PEND: begin
          if (ras == RAS_ALL) begin
            state_q         <= REFRESH;
            refresh_count_q <= refresh_count_q + 16'd1;
          end else if ((cas != CAS_ALL) || (ras != 4'b0000)) begin
            state_q <= IDLE;
          end
        end
        REFRESH: begin
          if (ras == 4'b0000) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A CAS edge coinciding with reset must not commit a write.
  simm_responder_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clock_i   (clock),
    .reset_i   (reset),
    .addr_i    (arr_addr),
    .wr_en_i   (access_fire && we && !reset),
    .wr_lanes_i(cas),
    .wr_data_i (data_in),
    .rd_en_i   (access_fire && !we && !reset),
    .rd_data_o (data_out)
  );

  assign data_oe       = data_oe_q;
  assign refresh_count = refresh_count_q;

`ifdef SIMM_RESPONDER_CHECK_EN
  localparam int INT_W = $clog2(REFRESH_LIMIT + 1);
  localparam logic [INT_W-1:0] LIMIT = INT_W'(REFRESH_LIMIT);

  logic [INT_W-1:0] interval_q, interval_d;
  logic             refresh_error_q;
  logic             protocol_error_q;

  always_comb begin
    interval_d = interval_q;
    if (refresh_fire) begin
      interval_d = '0;
    end else if (interval_q != LIMIT) begin
      interval_d = interval_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      interval_q       <= '0;
      refresh_error_q  <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      interval_q <= interval_d;
      if (!refresh_fire && (interval_d == LIMIT)) refresh_error_q <= 1'b1;
      if (proto_viol) protocol_error_q <= 1'b1;
    end
  end

  assign refresh_error  = refresh_error_q;
  assign protocol_error = protocol_error_q;
`else
  localparam int unused_refresh_limit = REFRESH_LIMIT;
  logic unused_proto_viol;
  assign unused_proto_viol = proto_viol;
  assign refresh_error     = 1'b0;
  assign protocol_error    = 1'b0;
`endif

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[11:ADDR_USED];

endmodule
